// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: widths, CSR addresses,
// mstatus field positions, per-register write masks and the misa value.
// Combinational definitions only; no state and no flow control.
package csr_pkg;

  localparam int XLEN = 64;

  // Implemented CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Bits a generic write is allowed to change
  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
  localparam logic [63:0] MIE_WMASK     = 64'h0000_0000_0000_0888;
  localparam logic [63:0] MTVEC_WMASK   = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] MEPC_WMASK    = 64'hFFFF_FFFF_FFFF_FFFE;

  // MXL=2 (64-bit), extensions I and M
  localparam logic [63:0] MISA_VALUE    = 64'h8000_0000_0000_1100;

  // Build the architectural mstatus view from the two stored enable bits;
  // MPP is hard-wired to machine mode.
  function automatic logic [63:0] mstatus_view(input logic mie, input logic mpie);
    logic [63:0] v;
    v                                = '0;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    v[MSTATUS_MIE]                   = mie;
    v[MSTATUS_MPIE]                  = mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr.sv
// Machine-mode CSR file: one combinational read port, one generic write port, trap-entry ports.
// Reads are zero latency; writes are visible the cycle after the capturing rising edge.
// No backpressure: every write is accepted in the cycle it is presented, never stalls.
module csr #(
  parameter int              XLEN    = csr_pkg::XLEN,
  parameter logic [XLEN-1:0] HART_ID = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [11:0]     waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            we_mtval_i,
  input  logic [XLEN-1:0] wdata_mtval_i,
  input  logic            we_mepc_i,
  input  logic [XLEN-1:0] wdata_mepc_i,
  input  logic            we_mcause_i,
  input  logic [XLEN-1:0] wdata_mcause_i,
  input  logic            exception_mie_req_i,
  input  logic [11:0]     raddr_i,
  output logic [XLEN-1:0] rdata_o
);
  import csr_pkg::*;

  // Only MIE and MPIE are real storage in mstatus; MPP and the rest are constant.
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [XLEN-1:0] mcycle_q;

  // One-hot decode of the generic write port onto the writable registers
  logic gen_mstatus;
  logic gen_mie;
  logic gen_mtvec;
  logic gen_mscratch;
  logic gen_mepc;
  logic gen_mcause;
  logic gen_mtval;
  logic gen_mcycle;

  // Decode the generic write address; read-only and unknown addresses fall through
  always_comb begin
    gen_mstatus  = 1'b0;
    gen_mie      = 1'b0;
    gen_mtvec    = 1'b0;
    gen_mscratch = 1'b0;
    gen_mepc     = 1'b0;
    gen_mcause   = 1'b0;
    gen_mtval    = 1'b0;
    gen_mcycle   = 1'b0;
    if (we_i) begin
      case (waddr_i)
        CSR_MSTATUS:  gen_mstatus  = 1'b1;
        CSR_MIE:      gen_mie      = 1'b1;
        CSR_MTVEC:    gen_mtvec    = 1'b1;
        CSR_MSCRATCH: gen_mscratch = 1'b1;
        CSR_MEPC:     gen_mepc     = 1'b1;
        CSR_MCAUSE:   gen_mcause   = 1'b1;
        CSR_MTVAL:    gen_mtval    = 1'b1;
        CSR_MCYCLE:   gen_mcycle   = 1'b1;
        default:      ;
      endcase
    end
  end

  // mstatus: trap entry saves MIE into MPIE and clears MIE, overriding any generic write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (exception_mie_req_i) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (gen_mstatus) begin
      mstatus_mie  <= wdata_i[MSTATUS_MIE];
      mstatus_mpie <= wdata_i[MSTATUS_MPIE];
    end
  end

  // Registers with only a generic write path; masked bits are stored as zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
    end else begin
      if (gen_mie)      mie_q      <= wdata_i & XLEN'(MIE_WMASK);
      if (gen_mtvec)    mtvec_q    <= wdata_i & XLEN'(MTVEC_WMASK);
      if (gen_mscratch) mscratch_q <= wdata_i;
    end
  end

  // Trap registers: the dedicated exception port takes priority over the generic port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      if (we_mepc_i)     mepc_q   <= wdata_mepc_i & XLEN'(MEPC_WMASK);
      else if (gen_mepc) mepc_q   <= wdata_i & XLEN'(MEPC_WMASK);

      if (we_mcause_i)     mcause_q <= wdata_mcause_i;
      else if (gen_mcause) mcause_q <= wdata_i;

      if (we_mtval_i)     mtval_q <= wdata_mtval_i;
      else if (gen_mtval) mtval_q <= wdata_i;
    end
  end

  // Free-running cycle counter; a generic write replaces that cycle's increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_q <= '0;
    end else if (gen_mcycle) begin
      mcycle_q <= wdata_i;
    end else begin
      mcycle_q <= mcycle_q + XLEN'(1);
    end
  end

  // Combinational read mux on current state; no bypass of same-cycle writes
  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CSR_MSTATUS:  rdata_o = XLEN'(mstatus_view(mstatus_mie, mstatus_mpie));
      CSR_MISA:     rdata_o = XLEN'(MISA_VALUE);
      CSR_MIE:      rdata_o = mie_q;
      CSR_MTVEC:    rdata_o = mtvec_q;
      CSR_MSCRATCH: rdata_o = mscratch_q;
      CSR_MEPC:     rdata_o = mepc_q;
      CSR_MCAUSE:   rdata_o = mcause_q;
      CSR_MTVAL:    rdata_o = mtval_q;
      CSR_MIP:      rdata_o = '0;
      CSR_MCYCLE:   rdata_o = mcycle_q;
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:   rdata_o = '0;
      CSR_MHARTID:  rdata_o = HART_ID;
      default:      rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_csr.sv
// Self-checking bench for the machine-mode CSR file.
// Directed tables and sequences, then random traffic against a register-map model.
// DUT has no backpressure; the bench drives one transaction per cycle.
module tb_csr;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [11:0] waddr_i;
  logic [63:0] wdata_i;
  logic        we_mtval_i;
  logic [63:0] wdata_mtval_i;
  logic        we_mepc_i;
  logic [63:0] wdata_mepc_i;
  logic        we_mcause_i;
  logic [63:0] wdata_mcause_i;
  logic        exception_mie_req_i;
  logic [11:0] raddr_i;
  logic [63:0] rdata_o;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [63:0] MISA = 64'h8000_0000_0000_1100;

  csr dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .wdata_i             (wdata_i),
    .we_mtval_i          (we_mtval_i),
    .wdata_mtval_i       (wdata_mtval_i),
    .we_mepc_i           (we_mepc_i),
    .wdata_mepc_i        (wdata_mepc_i),
    .we_mcause_i         (we_mcause_i),
    .wdata_mcause_i      (wdata_mcause_i),
    .exception_mie_req_i (exception_mie_req_i),
    .raddr_i             (raddr_i),
    .rdata_o             (rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic idle();
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    we_mtval_i = 1'b0; wdata_mtval_i = '0;
    we_mepc_i = 1'b0; wdata_mepc_i = '0;
    we_mcause_i = 1'b0; wdata_mcause_i = '0;
    exception_mie_req_i = 1'b0;
  endtask

  // ---------------- reference model: a map of address -> architectural value
  logic [63:0] st  [logic [11:0]];
  logic [63:0] nxt [logic [11:0]];

  // Which bits of each address a write may change (zero = not writable)
  function automatic logic [63:0] wmask(input logic [11:0] a);
    case (a)
      12'h300:                             return 64'h88;
      12'h304:                             return 64'h888;
      12'h305:                             return ~64'h3;
      12'h341:                             return ~64'h1;
      12'h340, 12'h342, 12'h343, 12'hB00:  return '1;
      default:                             return '0;
    endcase
  endfunction

  function automatic logic [63:0] model_read(input logic [11:0] a);
    if (a == 12'h301) return MISA;
    if (st.exists(a)) return st[a];
    return '0;
  endfunction

  task automatic model_reset();
    st.delete();
    st[12'h300] = 64'h1800;
    st[12'h304] = '0; st[12'h305] = '0;
    st[12'h340] = '0; st[12'h341] = '0; st[12'h342] = '0; st[12'h343] = '0;
    st[12'hB00] = '0;
  endtask

  // Next state from the current inputs, lowest priority first
  task automatic model_step();
    logic [63:0] m;
    nxt = st;
    nxt[12'hB00] = st[12'hB00] + 64'd1;
    m = wmask(waddr_i);
    if (we_i && m != 0 && !(waddr_i == 12'h300 && exception_mie_req_i))
      nxt[waddr_i] = (st[waddr_i] & ~m) | (wdata_i & m);
    if (we_mepc_i)   nxt[12'h341] = wdata_mepc_i & ~64'h1;
    if (we_mcause_i) nxt[12'h342] = wdata_mcause_i;
    if (we_mtval_i)  nxt[12'h343] = wdata_mtval_i;
    if (exception_mie_req_i)
      nxt[12'h300] = 64'h1800 | (st[12'h300][3] ? 64'h80 : 64'h0);
    st = nxt;
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 15))
      0: return 12'h300;  1: return 12'h301;  2: return 12'h304;  3: return 12'h305;
      4: return 12'h340;  5: return 12'h341;  6: return 12'h342;  7: return 12'h343;
      8: return 12'h344;  9: return 12'hB00; 10: return 12'hF11; 11: return 12'hF14;
      12: return 12'h7C0; 13: return 12'h300;
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  // ---------------- tables
  typedef struct {
    logic [11:0] addr;
    logic [63:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } wr_vec_t;

  rd_vec_t rst_tab [16];
  wr_vec_t wr_tab  [13];

  initial begin
    rst_tab = '{
      '{12'h300, 64'h1800}, '{12'h301, MISA}, '{12'h304, 0}, '{12'h305, 0},
      '{12'h340, 0}, '{12'h341, 0}, '{12'h342, 0}, '{12'h343, 0},
      '{12'h344, 0}, '{12'hB00, 0}, '{12'hF11, 0}, '{12'hF12, 0},
      '{12'hF13, 0}, '{12'hF14, 0}, '{12'h7C0, 0}, '{12'hFFF, 0}
    };
    wr_tab = '{
      '{12'h305, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC},
      '{12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1888},
      '{12'h300, 64'h0,                   64'h1800},
      '{12'h304, 64'hFFFF_FFFF_FFFF_FFFF, 64'h888},
      '{12'h340, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF},
      '{12'h341, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE},
      '{12'h342, 64'h8000_0000_0000_000B, 64'h8000_0000_0000_000B},
      '{12'h343, 64'hCAFE,                64'hCAFE},
      '{12'h344, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
      '{12'h301, 64'h0,                   MISA},
      '{12'hF14, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
      '{12'hF11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
      '{12'h7C0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0}
    };

    rst = 1'b0;
    idle();
    raddr_i = '0;

    // Reset values, read while reset is held
    #1;
    for (int i = 0; i < 16; i++) begin
      raddr_i = rst_tab[i].addr;
      #1;
      check($sformatf("reset_%03h", rst_tab[i].addr), rdata_o, rst_tab[i].exp);
    end
    raddr_i = 12'hB00;
    repeat (2) @(posedge clk);
    #1 check("mcycle_held_in_reset", rdata_o, 64'd0);

    // mcycle counts 0,1,2 from the first edge after reset
    @(negedge clk) rst = 1'b1;
    #1 check("mcycle_0", rdata_o, 64'd0);
    @(negedge clk); #1 check("mcycle_1", rdata_o, 64'd1);
    @(negedge clk); #1 check("mcycle_2", rdata_o, 64'd2);

    // mtvec: same-cycle read returns old value, next cycle masked value
    @(negedge clk);
    we_i = 1'b1; waddr_i = 12'h305; wdata_i = '1; raddr_i = 12'h305;
    #1 check("mtvec_same_cycle", rdata_o, 64'h0);
    @(negedge clk) idle();
    #1 check("mtvec_next", rdata_o, 64'hFFFF_FFFF_FFFF_FFFC);

    // mstatus write then trap entry
    @(negedge clk);
    we_i = 1'b1; waddr_i = 12'h300; wdata_i = 64'h8; raddr_i = 12'h300;
    @(negedge clk) idle();
    #1 check("mstatus_mie_set", rdata_o, 64'h1808);
    exception_mie_req_i = 1'b1;
    @(negedge clk) idle();
    #1 check("mstatus_trap", rdata_o, 64'h1880);
    // trap entry beats a simultaneous generic write (MIE now 0 -> MPIE 0)
    exception_mie_req_i = 1'b1;
    we_i = 1'b1; waddr_i = 12'h300; wdata_i = 64'h88;
    @(negedge clk) idle();
    #1 check("mstatus_trap_wins", rdata_o, 64'h1800);

    // Dedicated exception writes alongside a colliding generic mepc write
    we_mepc_i = 1'b1;   wdata_mepc_i = 64'h8000_0004;
    we_mcause_i = 1'b1; wdata_mcause_i = 64'd2;
    we_mtval_i = 1'b1;  wdata_mtval_i = 64'hDEAD;
    we_i = 1'b1; waddr_i = 12'h341; wdata_i = 64'h1234;
    @(negedge clk) idle();
    raddr_i = 12'h341; #1 check("mepc_exc_wins", rdata_o, 64'h8000_0004);
    raddr_i = 12'h342; #1 check("mcause_exc", rdata_o, 64'd2);
    raddr_i = 12'h343; #1 check("mtval_exc", rdata_o, 64'hDEAD);

    // mcycle load suppresses that cycle's increment
    @(negedge clk);
    we_i = 1'b1; waddr_i = 12'hB00; wdata_i = 64'd100; raddr_i = 12'hB00;
    @(negedge clk) idle();
    #1 check("mcycle_load", rdata_o, 64'd100);
    @(negedge clk); #1 check("mcycle_after_load", rdata_o, 64'd101);

    // Table of single generic writes, each read back the next cycle
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      we_i = 1'b1; waddr_i = wr_tab[i].waddr; wdata_i = wr_tab[i].wdata;
      raddr_i = wr_tab[i].waddr;
      @(negedge clk) idle();
      #1 check($sformatf("wr_%0d_%03h", i, wr_tab[i].waddr), rdata_o, wr_tab[i].exp);
    end

    // Random traffic against the model, from a fresh reset
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      we_i = ($urandom_range(0, 2) == 0);
      waddr_i = pick_addr(); wdata_i = rnd64();
      we_mepc_i = ($urandom_range(0, 5) == 0);   wdata_mepc_i = rnd64();
      we_mcause_i = ($urandom_range(0, 5) == 0); wdata_mcause_i = rnd64();
      we_mtval_i = ($urandom_range(0, 5) == 0);  wdata_mtval_i = rnd64();
      exception_mie_req_i = ($urandom_range(0, 5) == 0);
      raddr_i = pick_addr();
      #1 check($sformatf("rand_%0d_%03h", i, raddr_i), rdata_o, model_read(raddr_i));
      model_step();
      @(negedge clk);
    end
    idle();

    // Asynchronous reset clears state without a clock edge
    we_i = 1'b1; waddr_i = 12'h340; wdata_i = 64'h55; raddr_i = 12'h340;
    @(negedge clk) idle();
    #1 check("mscratch_before_rst", rdata_o, 64'h55);
    @(posedge clk);
    we_i = 1'b1; waddr_i = 12'h340; wdata_i = 64'hFF;
    #2 rst = 1'b0;
    #1 check("mscratch_async_rst", rdata_o, 64'h0);
    raddr_i = 12'hB00;
    #1 check("mcycle_async_rst", rdata_o, 64'h0);
    @(posedge clk);
    raddr_i = 12'h340;
    #1 check("mscratch_write_in_rst", rdata_o, 64'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
